// File: rtl/echo_delay_if.sv
// Valid/ready sample stream between effect stages.
// Latency: none (wires only).
// Backpressure: the producer holds data/valid stable until it sees ready.
// Ports: none; the master modport drives data/valid, the slave modport drives ready.
interface echo_delay_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/echo_delay.sv
// Feedback echo: out = dry + mix*delayed, buffer <= dry + feedback*delayed (saturating).
// Latency: accept on edge N, out_valid high after edge N+2 and sampled at N+3; one sample per 4 cycles.
// Backpressure: holds the result until dst.ready; src.ready is low outside IDLE and while clearing.
// Ports: clk/reset (sync, active-high); bypass, delay_len, feedback_gain, mix_gain are
// control values latched per sample; src = input stream, dst = output stream;
// sat_flag is a sticky saturation indicator cleared only by reset.
module echo_delay #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12,
   parameter int GAIN_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bypass,
   input  logic [ADDR_W-1:0] delay_len,
   input  logic [GAIN_W-1:0] feedback_gain,
   input  logic [GAIN_W-1:0] mix_gain,
   echo_delay_if.slave       src,
   echo_delay_if.master      dst,
   output logic              sat_flag
);
   localparam logic [2:0] S_CLEAR = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_CALC  = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;

   localparam int PROD_W = DATA_W + GAIN_W + 1;
   localparam int SUM_W  = DATA_W + 1;

   localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

   logic [2:0]        state;
   logic [ADDR_W-1:0] clr_addr;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] tap;

   // per-sample copies of the input and controls
   logic [DATA_W-1:0] smp;
   logic              byp_q;
   logic [ADDR_W-1:0] dly_q;
   logic [GAIN_W-1:0] fbg_q;
   logic [GAIN_W-1:0] mxg_q;

   logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
   logic [DATA_W-1:0] rd_dat;

   logic [DATA_W-1:0] out_data;
   logic              out_valid;

   logic signed [PROD_W-1:0] dly_x;
   logic signed [PROD_W-1:0] fbg_x;
   logic signed [PROD_W-1:0] mxg_x;
   logic signed [SUM_W-1:0]  smp_x;
   logic signed [SUM_W-1:0]  fb_sum;
   logic signed [SUM_W-1:0]  wet_sum;
   logic                     fb_ovf;
   logic                     wet_ovf;
   logic [DATA_W-1:0]        fb_val;
   logic [DATA_W-1:0]        wet_val;

   assign src.ready = (state == S_IDLE);
   assign dst.data  = out_data;
   assign dst.valid = out_valid;

   // modular subtraction gives the circular-buffer tap directly
   assign tap = wr_ptr - dly_q;

   always_comb begin
      dly_x = '0;
      if (dly_q != '0) begin
         dly_x = {{(GAIN_W+1){rd_dat[DATA_W-1]}}, rd_dat};
      end
      fbg_x = {{(DATA_W+1){1'b0}}, fbg_q};
      mxg_x = {{(DATA_W+1){1'b0}}, mxg_q};
      smp_x = {smp[DATA_W-1], smp};
      // |delayed * gain / 2^GAIN_W| < 2^(DATA_W-1), so the low SUM_W bits hold the scaled value exactly
      fb_sum  = smp_x + SUM_W'((dly_x * fbg_x) >>> GAIN_W);
      wet_sum = smp_x + SUM_W'((dly_x * mxg_x) >>> GAIN_W);
      fb_ovf  = fb_sum[SUM_W-1]  ^ fb_sum[SUM_W-2];
      wet_ovf = wet_sum[SUM_W-1] ^ wet_sum[SUM_W-2];
      fb_val  = fb_ovf  ? (fb_sum[SUM_W-1]  ? MIN_VAL : MAX_VAL) : fb_sum[DATA_W-1:0];
      wet_val = wet_ovf ? (wet_sum[SUM_W-1] ? MIN_VAL : MAX_VAL) : wet_sum[DATA_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_CLEAR;
         clr_addr  <= '0;
         wr_ptr    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         sat_flag  <= 1'b0;
      end else begin
         case (state)
            S_CLEAR: begin
               clr_addr <= clr_addr + 1'b1;
               if (clr_addr == '1) begin
                  state <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (src.valid) begin
                  smp   <= src.data;
                  byp_q <= bypass;
                  dly_q <= delay_len;
                  fbg_q <= feedback_gain;
                  mxg_q <= mix_gain;
                  state <= S_READ;
               end
            end
            S_READ: begin
               state <= S_CALC;
            end
            S_CALC: begin
               wr_ptr    <= wr_ptr + 1'b1;
               out_data  <= byp_q ? smp : wet_val;
               out_valid <= 1'b1;
               // saturation is reported even when the wet path is bypassed
               if (fb_ovf || wet_ovf) begin
                  sat_flag <= 1'b1;
               end
               state <= S_OUT;
            end
            S_OUT: begin
               if (dst.ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_CLEAR;
            end
         endcase
      end
   end

   // Buffer port: writes are suppressed during reset so an interrupted sample leaves no trace.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == S_CLEAR) begin
            mem[clr_addr] <= '0;
         end else if (state == S_CALC) begin
            mem[wr_ptr] <= fb_val;
         end
      end
      if (state == S_READ) begin
         rd_dat <= mem[tap];
      end
   end
endmodule

// File: tb/tb_echo_delay.sv
// Directed bench for echo_delay: clear timing, echo scaling, backpressure,
// saturation, reset mid-sample and a long wrapping stream with bypass windows.
module tb_echo_delay;
   logic        clk = 1'b0;
   logic        reset;
   logic        bypass;
   logic [11:0] delay_len;
   logic [7:0]  feedback_gain;
   logic [7:0]  mix_gain;
   logic        sat_flag;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   echo_delay_if #(.DATA_W(32)) src ();
   echo_delay_if #(.DATA_W(32)) dst ();

   echo_delay #(.DATA_W(32), .ADDR_W(12), .GAIN_W(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .bypass        (bypass),
      .delay_len     (delay_len),
      .feedback_gain (feedback_gain),
      .mix_gain      (mix_gain),
      .src           (src),
      .dst           (dst),
      .sat_flag      (sat_flag)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full sample: present, wait for accept, wait for result, take it (dst.ready assumed 1).
   task automatic xfer(input logic [31:0] d, input logic byp, input logic [11:0] dl,
                       input logic [7:0] fg, input logic [7:0] mg, output logic [31:0] q);
      int n;
      src.data = d; bypass = byp; delay_len = dl;
      feedback_gain = fg; mix_gain = mg; src.valid = 1'b1;
      @(negedge clk);
      n = 0;
      while (src.ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", src.ready, 1);
      @(posedge clk);
      #1 src.valid = 1'b0;
      @(negedge clk);
      n = 0;
      while (dst.valid !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("out_valid_wait", dst.valid, 1);
      q = dst.data;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] q;
      int          cnt;
      int          seen;
      int          x;
      int          hx;
      int          e;
      logic        byp;
      logic [31:0] e3 [10];
      e3 = '{32'd1024, 32'd0, 32'd1020, 32'd0, 32'd510, 32'd0, 32'd255, 32'd0, 32'd127, 32'd0};

      // ---- reset state, then in_valid held through the clear sweep ----
      reset = 1'b1; src.valid = 1'b1; src.data = 32'd1000; bypass = 1'b0;
      delay_len = 12'd4; feedback_gain = 8'd0; mix_gain = 8'd128; dst.ready = 1'b1;
      @(posedge clk); @(posedge clk); @(negedge clk);
      check("rst_in_ready", src.ready, 0);
      check("rst_out_valid", dst.valid, 0);
      check("rst_out_data", dst.data, 0);
      check("rst_sat_flag", sat_flag, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      cnt = 0;
      @(negedge clk);
      while (src.ready !== 1'b1 && cnt < 5000) begin
         cnt++;
         @(negedge clk);
      end
      check("clear_cycles", cnt, 4096);
      @(posedge clk);                       // accept edge N
      #1 src.valid = 1'b0; src.data = 32'd0;
      @(negedge clk);
      check("lat_in_ready_read", src.ready, 0);
      check("lat_valid_n0", dst.valid, 0);
      @(negedge clk);
      check("lat_valid_n1", dst.valid, 0);
      @(negedge clk);                       // value presented at edge N+3
      check("lat_valid_n2", dst.valid, 1);
      check("impulse_out", dst.data, 1000);
      @(posedge clk);
      @(negedge clk);
      check("thru_valid_low", dst.valid, 0);
      check("thru_ready_back", src.ready, 1);
      @(posedge clk);
      #1;

      // ---- delay 4, mix 128, no feedback: single half-level echo ----
      for (int i = 1; i < 10; i++) begin
         xfer(32'd0, 1'b0, 12'd4, 8'd0, 8'd128, q);
         check("echo_d4", q, (i == 4) ? 32'd500 : 32'd0);
      end

      // ---- delay 2, mix 255, feedback 128: decaying chain ----
      for (int i = 0; i < 10; i++) begin
         xfer((i == 0) ? 32'd1024 : 32'd0, 1'b0, 12'd2, 8'd128, 8'd255, q);
         check("echo_fb_chain", q, e3[i]);
      end

      // ---- backpressure: out_ready low for 10 cycles ----
      dst.ready = 1'b0; src.data = 32'd555; bypass = 1'b0; delay_len = 12'd0;
      feedback_gain = 8'd255; mix_gain = 8'd255; src.valid = 1'b1;
      @(negedge clk);
      cnt = 0;
      while (src.ready !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      @(posedge clk);
      #1 src.data = 32'd777;                // stays valid; must not be taken
      cnt = 0;
      @(negedge clk);
      while (dst.valid !== 1'b1 && cnt < 8) begin
         @(negedge clk);
         cnt++;
      end
      check("bp_valid", dst.valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold_data", dst.data, 555);
         check("bp_hold_valid", dst.valid, 1);
         check("bp_in_ready", src.ready, 0);
      end
      @(posedge clk);
      #1 dst.ready = 1'b1;
      @(posedge clk);                       // the one transfer
      #1 src.valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (dst.valid === 1'b1) seen++;
      end
      check("bp_single_xfer", seen, 0);
      check("bp_idle_ready", src.ready, 1);
      @(posedge clk);
      #1;

      // ---- saturation, positive and negative ----
      xfer(32'h7FFF_FFF0, 1'b0, 12'd1, 8'd0, 8'd0, q);
      check("sat_pre_out", q, 32'h7FFF_FFF0);
      check("sat_pre_flag", sat_flag, 0);
      xfer(32'h7FFF_FFF0, 1'b0, 12'd1, 8'd0, 8'd255, q);
      check("sat_pos_out", q, 32'h7FFF_FFFF);
      check("sat_pos_flag", sat_flag, 1);
      xfer(32'h8000_0010, 1'b0, 12'd1, 8'd0, 8'd0, q);
      check("sat_neg_pre", q, 32'h8000_0010);
      xfer(32'h8000_0010, 1'b0, 12'd1, 8'd0, 8'd255, q);
      check("sat_neg_out", q, 32'h8000_0000);

      // ---- reset while the sample sits in CALC ----
      src.data = 32'd42; delay_len = 12'd3; mix_gain = 8'd128; src.valid = 1'b1;
      @(negedge clk);
      cnt = 0;
      while (src.ready !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      @(posedge clk);                       // accept
      #1 src.valid = 1'b0;
      @(posedge clk);                       // now in CALC
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rc_out_valid", dst.valid, 0);
      check("rc_out_data", dst.data, 0);
      check("rc_sat_flag", sat_flag, 0);
      cnt = 0;
      seen = 0;
      while (src.ready !== 1'b1 && cnt < 5000) begin
         if (dst.valid === 1'b1) seen++;
         cnt++;
         @(negedge clk);
      end
      check("rc_clear_cycles", cnt, 4096);
      check("rc_no_output", seen, 0);
      @(posedge clk);
      #1;

      // ---- 5000-sample stream, delay 4095, bypass windows ----
      for (int n = 0; n < 5000; n++) begin
         x   = n * 3 - 7000;
         byp = ((n >= 100) && (n < 200)) || ((n >= 4090) && (n < 4110));
         xfer(x, byp, 12'd4095, 8'd0, 8'd128, q);
         if (byp) begin
            e = x;
         end else if (n >= 4095) begin
            hx = (n - 4095) * 3 - 7000;
            e  = x + (hx >>> 1);
         end else begin
            e = x;
         end
         check("stream", q, e);
      end
      check("stream_no_sat", sat_flag, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
